stream_rx_responder: RTL and testbench

STREAM_RX_RESPONDER -- requirements
Module: stream_rx_responder

---
 rtl/stream_rx_responder_pkg.sv | 31 +++
 rtl/stream_rx_watchdog.sv | 29 ++
 rtl/stream_rx_responder.sv | 148 ++++++++++++++
 tb/tb_stream_rx_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rx_responder_pkg.sv
// Shared definitions for the stream receive responder: FSM encoding,
// request/response field layout and beat-size helpers.
package stream_rx_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESP     = 2'd1,
    ST_DATA     = 2'd2,
    ST_ERR_RESP = 2'd3
  } state_t;

  // Request word layout: [31:0] length in bytes, [47:32] channel id.
  localparam int REQ_LEN_LSB  = 0;
  localparam int REQ_LEN_W    = 32;
  localparam int REQ_CHAN_LSB = 32;
  localparam int REQ_CHAN_W   = 16;

  // The response echoes the low 48 request bits; bit 63 flags a rejected request.
  localparam int ECHO_W       = 48;
  localparam int RESP_ERR_BIT = 63;

  localparam int BYTES_PER_BEAT = 64;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int BEATS_W        = 27;

  // ceil(len / 64); a 32-bit length needs at most 2^26 beats, so 27 bits suffice.
  function automatic logic [BEATS_W-1:0] calc_beats(input logic [REQ_LEN_W-1:0] len);
    return BEATS_W'(len >> BEAT_SHIFT) + BEATS_W'(|len[BEAT_SHIFT-1:0]);
  endfunction

endpackage

// File: rtl/stream_rx_watchdog.sv
// Idle-data watchdog: counts consecutive enabled cycles without a clear and
// flags expiry once the count reaches TIMEOUT_CYCLES.
module stream_rx_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count idle cycles; hold at the terminal value so expiry stays asserted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TERMINAL)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == TERMINAL);

endmodule

// File: rtl/stream_rx_responder.sv
// Request/response front end with a counted payload pass-through.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | ready for a request; decode length and pick next state
//   ST_RESP     | presenting the good response (bit 63 = 0)
//   ST_DATA     | forwarding payload beats until the counter hits zero
//   ST_ERR_RESP | presenting the error response (bit 63 = 1), no payload
module stream_rx_responder
  import stream_rx_responder_pkg::*;
#(
  parameter int MAX_LEN        = 65536,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         ap_clk,
  input  logic         ap_rst,

  input  logic         s_axis_tx_req_TVALID,
  output logic         s_axis_tx_req_TREADY,
  input  logic [63:0]  s_axis_tx_req_TDATA,

  output logic         m_axis_tx_resp_TVALID,
  input  logic         m_axis_tx_resp_TREADY,
  output logic [63:0]  m_axis_tx_resp_TDATA,

  input  logic         s_axis_tx_data_TVALID,
  output logic         s_axis_tx_data_TREADY,
  input  logic [511:0] s_axis_tx_data_TDATA,

  output logic         m_axis_data_TVALID,
  input  logic         m_axis_data_TREADY,
  output logic [511:0] m_axis_data_TDATA,
  output logic         m_axis_data_TLAST,

  output logic         detect_fault,
  output logic [31:0]  xfer_count
);

  state_t               state;
  logic [BEATS_W-1:0]   beats_q;
  logic [BEATS_W-1:0]   beat_cnt;
  logic                 resp_valid_q;
  logic [63:0]          resp_data_q;
  logic                 fault_q;
  logic [31:0]          xfer_q;

  logic [REQ_LEN_W-1:0] req_len;
  logic                 len_ok;
  logic [63:0]          resp_word;
  logic                 in_data;
  logic                 data_hs;
  logic                 wd_clear;
  logic                 wd_expired;
  logic                 unused_req_bits;

  assign req_len         = s_axis_tx_req_TDATA[REQ_LEN_LSB +: REQ_LEN_W];
  assign unused_req_bits = ^s_axis_tx_req_TDATA[63:ECHO_W];

  // Accept 1..MAX_LEN; widen by one bit so a 32-bit length cannot wrap the compare.
  assign len_ok = (req_len != '0) && ({1'b0, req_len} <= 33'(MAX_LEN));

  // Response word: echo of request bits [47:0], zero padding, error flag on top.
  always_comb begin
    resp_word               = '0;
    resp_word[ECHO_W-1:0]   = s_axis_tx_req_TDATA[ECHO_W-1:0];
    resp_word[RESP_ERR_BIT] = ~len_ok;
  end

  assign in_data = (state == ST_DATA);
  assign data_hs = in_data && s_axis_tx_data_TVALID && m_axis_data_TREADY;

  // Downstream back-pressure is not the source's fault, so it also clears the timer.
  assign wd_clear = !in_data || data_hs || !m_axis_data_TREADY;

  stream_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .clear  (wd_clear),
    .enable (in_data),
    .expired(wd_expired)
  );

  // Main sequencer: request decode, response hold, beat countdown and timeout abort.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= ST_IDLE;
      beats_q      <= '0;
      beat_cnt     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      fault_q      <= 1'b0;
      xfer_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_axis_tx_req_TVALID) begin
            beats_q      <= calc_beats(req_len);
            resp_data_q  <= resp_word;
            resp_valid_q <= 1'b1;
            state        <= len_ok ? ST_RESP : ST_ERR_RESP;
          end
        end
        ST_RESP: begin
          if (m_axis_tx_resp_TREADY) begin
            resp_valid_q <= 1'b0;
            beat_cnt     <= beats_q;
            state        <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_hs) begin
            beat_cnt <= beat_cnt - BEATS_W'(1);
            if (beat_cnt == BEATS_W'(1)) begin
              xfer_q <= xfer_q + 32'd1;
              state  <= ST_IDLE;
            end
          end else if (wd_expired) begin
            fault_q  <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        ST_ERR_RESP: begin
          if (m_axis_tx_resp_TREADY) begin
            resp_valid_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tx_req_TREADY  = (state == ST_IDLE);
  assign m_axis_tx_resp_TVALID = resp_valid_q;
  assign m_axis_tx_resp_TDATA  = resp_data_q;

  assign s_axis_tx_data_TREADY = in_data && m_axis_data_TREADY;
  assign m_axis_data_TVALID    = in_data && s_axis_tx_data_TVALID;
  assign m_axis_data_TDATA     = s_axis_tx_data_TDATA;
  assign m_axis_data_TLAST     = in_data && (beat_cnt == BEATS_W'(1));

  assign detect_fault = fault_q;
  assign xfer_count   = xfer_q;

endmodule

// File: tb/tb_stream_rx_responder.sv
// Self-checking bench for stream_rx_responder: directed table, random
// requests against a behavioural model, reset and timeout sequences.
module tb_stream_rx_responder;

  localparam int MAX_LEN = 1024;
  localparam int TIMEOUT = 32;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [63:0]  req_data = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [63:0]  resp_data;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic [511:0] data_tdata = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [511:0] m_data;
  logic         m_last;
  logic         detect_fault;
  logic [31:0]  xfer_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  bit exp_fault = 1'b0;

  typedef struct {
    logic [31:0] len;
    logic [15:0] chan;
    logic [63:0] resp;
    int          beats;
  } vec_t;

  vec_t vecs[8];

  always #5 ap_clk = ~ap_clk;

  stream_rx_responder #(
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .s_axis_tx_req_TVALID(req_valid),
    .s_axis_tx_req_TREADY(req_ready),
    .s_axis_tx_req_TDATA(req_data),
    .m_axis_tx_resp_TVALID(resp_valid),
    .m_axis_tx_resp_TREADY(resp_ready),
    .m_axis_tx_resp_TDATA(resp_data),
    .s_axis_tx_data_TVALID(data_valid),
    .s_axis_tx_data_TREADY(data_ready),
    .s_axis_tx_data_TDATA(data_tdata),
    .m_axis_data_TVALID(m_valid),
    .m_axis_data_TREADY(m_ready),
    .m_axis_data_TDATA(m_data),
    .m_axis_data_TLAST(m_last),
    .detect_fault(detect_fault),
    .xfer_count(xfer_count)
  );

  task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: error when length is zero or exceeds MAX_LEN.
  function automatic bit ref_err(input logic [31:0] len);
    return (len == 0) || (longint'(len) > longint'(MAX_LEN));
  endfunction

  function automatic logic [63:0] ref_resp(input logic [31:0] len, input logic [15:0] chan);
    return {ref_err(len), 15'd0, chan, len};
  endfunction

  function automatic int ref_beats(input logic [31:0] len);
    if (ref_err(len)) return 0;
    return int'((longint'(len) + 63) / 64);
  endfunction

  function automatic logic [511:0] rand_beat();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_req(input logic [31:0] len, input logic [15:0] chan);
    int n = 0;
    req_valid = 1'b1;
    req_data  = {16'($urandom), chan, len};
    while (!req_ready && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) chk(1'b0, "req_accept_timeout", 512'(req_ready), 512'(1));
    @(negedge ap_clk);
    req_valid = 1'b0;
  endtask

  task automatic get_resp(input logic [63:0] e_resp, input bit rnd);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 200) begin
      resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (resp_valid && resp_ready) begin
        chk(resp_data == e_resp, "resp_data", 512'(resp_data), 512'(e_resp));
        got = 1'b1;
      end
      @(negedge ap_clk);
      n++;
    end
    resp_ready = 1'b0;
    if (!got) chk(1'b0, "resp_timeout", 512'(resp_valid), 512'(1));
  endtask

  task automatic data_phase(input int beats, input bit rnd);
    logic [511:0] q[$];
    int recv = 0;
    int n = 0;
    bit hs;
    for (int i = 0; i < beats; i++) q.push_back(rand_beat());
    while (recv < beats && n < 4000) begin
      if (!data_valid) data_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_tdata = q[recv];
      m_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk(m_valid == data_valid, "m_valid_passthru", 512'(m_valid), 512'(data_valid));
      chk(data_ready == m_ready, "data_ready_passthru", 512'(data_ready), 512'(m_ready));
      hs = data_valid && m_ready;
      if (hs) begin
        chk(m_data == q[recv], "beat_data", m_data, q[recv]);
        chk(m_last == (recv == beats - 1), "tlast", 512'(m_last), 512'(recv == beats - 1));
        if (recv == beats - 1) chk(req_ready == 1'b0, "req_ready_last_beat", 512'(req_ready), 512'(0));
        recv++;
      end
      @(negedge ap_clk);
      if (hs) data_valid = 1'b0;
      n++;
    end
    if (recv < beats) chk(1'b0, "data_budget", 512'(recv), 512'(beats));
    data_valid = 1'b0;
    m_ready    = 1'b0;
  endtask

  task automatic err_idle_check();
    data_valid = 1'b1;
    m_ready    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk(data_ready == 1'b0, "err_data_ready", 512'(data_ready), 512'(0));
      chk(m_valid == 1'b0, "err_m_valid", 512'(m_valid), 512'(0));
      @(negedge ap_clk);
    end
    data_valid = 1'b0;
    m_ready    = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] len, input logic [15:0] chan,
                          input logic [63:0] e_resp, input int e_beats, input bit rnd);
    send_req(len, chan);
    get_resp(e_resp, rnd);
    if (e_beats == 0) begin
      err_idle_check();
    end else begin
      data_phase(e_beats, rnd);
      exp_count++;
    end
    chk(xfer_count == 32'(exp_count), "xfer_count", 512'(xfer_count), 512'(exp_count));
    chk(detect_fault == exp_fault, "detect_fault", 512'(detect_fault), 512'(exp_fault));
    chk(req_ready == 1'b1, "req_ready_idle", 512'(req_ready), 512'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] len;
    logic [15:0] chan;
    int first_fault;

    vecs[0] = '{32'd128,  16'd5, 64'h0000_0005_0000_0080, 2};
    vecs[1] = '{32'd65,   16'd1, 64'h0000_0001_0000_0041, 2};
    vecs[2] = '{32'd64,   16'd2, 64'h0000_0002_0000_0040, 1};
    vecs[3] = '{32'd0,    16'd3, 64'h8000_0003_0000_0000, 0};
    vecs[4] = '{32'd1025, 16'd4, 64'h8000_0004_0000_0401, 0};
    vecs[5] = '{32'd1024, 16'd6, 64'h0000_0006_0000_0400, 16};
    vecs[6] = '{32'd1,    16'd7, 64'h0000_0007_0000_0001, 1};
    vecs[7] = '{32'd256,  16'd8, 64'h0000_0008_0000_0100, 4};

    // Reset state
    repeat (3) @(negedge ap_clk);
    chk(resp_valid == 1'b0, "rst_resp_valid", 512'(resp_valid), 512'(0));
    chk(req_ready == 1'b1, "rst_req_ready", 512'(req_ready), 512'(1));
    chk(detect_fault == 1'b0, "rst_fault", 512'(detect_fault), 512'(0));
    chk(xfer_count == 32'd0, "rst_xfer_count", 512'(xfer_count), 512'(0));
    chk(m_valid == 1'b0, "rst_m_valid", 512'(m_valid), 512'(0));
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // Directed table
    for (int i = 0; i < 8; i++)
      run_xfer(vecs[i].len, vecs[i].chan, vecs[i].resp, vecs[i].beats, i[0]);

    // Random requests against the model, random handshakes
    for (int i = 0; i < 14; i++) begin
      len  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1100));
      chan = 16'($urandom);
      run_xfer(len, chan, ref_resp(len, chan), ref_beats(len), 1'b1);
    end

    // Reset during beat 2 of 4
    send_req(32'd256, 16'd9);
    get_resp(ref_resp(32'd256, 16'd9), 1'b0);
    data_valid = 1'b1; m_ready = 1'b1; data_tdata = rand_beat();
    @(negedge ap_clk);
    data_tdata = rand_beat();
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    exp_count = 0;
    exp_fault = 1'b0;
    chk(m_valid == 1'b0, "rst_mid_m_valid", 512'(m_valid), 512'(0));
    chk(m_last == 1'b0, "rst_mid_tlast", 512'(m_last), 512'(0));
    chk(resp_valid == 1'b0, "rst_mid_resp_valid", 512'(resp_valid), 512'(0));
    chk(xfer_count == 32'd0, "rst_mid_xfer_count", 512'(xfer_count), 512'(0));
    chk(data_ready == 1'b0, "rst_mid_data_ready", 512'(data_ready), 512'(0));
    chk(req_ready == 1'b1, "rst_mid_req_ready", 512'(req_ready), 512'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk(m_valid == 1'b0 && m_last == 1'b0, "post_rst_no_beat", 512'(m_valid), 512'(0));
      chk(resp_valid == 1'b0, "post_rst_no_resp", 512'(resp_valid), 512'(0));
    end
    data_valid = 1'b0; m_ready = 1'b0;
    run_xfer(32'd64, 16'd10, ref_resp(32'd64, 16'd10), 1, 1'b0);

    // Timeout after one beat of a two-beat transfer
    send_req(32'd128, 16'd11);
    get_resp(ref_resp(32'd128, 16'd11), 1'b0);
    data_valid = 1'b1; m_ready = 1'b1; data_tdata = rand_beat();
    @(negedge ap_clk);
    data_valid = 1'b0;
    first_fault = -1;
    for (int k = 1; k <= TIMEOUT + 6 && first_fault < 0; k++) begin
      @(negedge ap_clk);
      if (detect_fault) first_fault = k;
    end
    chk(first_fault >= TIMEOUT && first_fault <= TIMEOUT + 2, "fault_timing",
        512'(first_fault), 512'(TIMEOUT + 1));
    chk(req_ready == 1'b1, "fault_back_idle", 512'(req_ready), 512'(1));
    exp_fault = 1'b1;
    m_ready = 1'b0;
    @(negedge ap_clk);
    chk(detect_fault == 1'b1, "fault_sticky", 512'(detect_fault), 512'(1));
    run_xfer(32'd200, 16'd12, ref_resp(32'd200, 16'd12), 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
